// File: rtl/ad9228_lvds_tx_emulator.sv
// AD9228-style serial LVDS transmit emulator: serializes one sample per lane per frame,
// MSB first, with matching frame clock (fco) and DDR data clock (dco).
module ad9228_lvds_tx_emulator #(
    parameter int                    NUM_CHANNELS  = 4,
    parameter int                    DATA_WIDTH    = 12,
    parameter int                    TRAIN_FRAMES  = 2,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 12'hA5C,
    parameter bit                    DOUT_INVERTED = 1'b0,
    parameter bit                    FCO_INVERTED  = 1'b0
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               en,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_data,
    output logic [NUM_CHANNELS-1:0]            dout,
    output logic                               fco,
    output logic                               dco,
    output logic                               frame_start,
    output logic [15:0]                        underflow_count
);

    localparam int SW = NUM_CHANNELS * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int TW = (TRAIN_FRAMES > 1) ? $clog2(TRAIN_FRAMES) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] HALF_BIT   = CW'(DATA_WIDTH / 2);
    localparam logic [TW-1:0] TRAIN_LAST = TW'((TRAIN_FRAMES > 0) ? TRAIN_FRAMES - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_bit_cnt;
    logic [TW-1:0]           r_train_cnt;
    logic [SW-1:0]           r_shift;
    logic [SW-1:0]           r_hold;
    logic                    r_hold_valid;
    logic [15:0]             r_underflow;
    logic [NUM_CHANNELS-1:0] r_dout;
    logic                    r_fco;
    logic                    r_dco;
    logic                    r_frame_start;

    logic                    w_active;
    logic                    w_last;
    logic                    w_boundary;
    logic                    w_train_next;
    logic                    w_accept;
    logic [NUM_CHANNELS-1:0] w_bits;

    assign w_active     = (r_state != ST_IDLE);
    assign w_last       = (r_bit_cnt == LAST_BIT);
    assign w_boundary   = w_active && w_last && en;
    assign w_train_next = (r_state == ST_TRAIN) && (r_train_cnt != TRAIN_LAST);
    assign w_accept     = s_valid && !r_hold_valid;

    // The shift word is held static for the whole frame; bit_cnt selects the bit.
    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_lane;
            assign w_lane     = r_shift[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_bits[gi] = w_lane[LAST_BIT - r_bit_cnt];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (en) w_state_next = ST_TRAIN;
            ST_TRAIN: if (w_last) begin
                          if (!en)                             w_state_next = ST_IDLE;
                          else if (r_train_cnt == TRAIN_LAST) w_state_next = ST_RUN;
                      end
            ST_RUN:   if (w_last && !en) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_train_cnt   <= '0;
            r_shift       <= '0;
            r_hold        <= '0;
            r_hold_valid  <= 1'b0;
            r_underflow   <= '0;
            r_dout        <= {NUM_CHANNELS{DOUT_INVERTED}};
            r_fco         <= FCO_INVERTED;
            r_dco         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_active) begin
                r_dout        <= w_bits ^ {NUM_CHANNELS{DOUT_INVERTED}};
                r_fco         <= (r_bit_cnt < HALF_BIT) ^ FCO_INVERTED;
                r_dco         <= ~r_bit_cnt[0];
                r_frame_start <= (r_bit_cnt == '0);
            end else begin
                r_dout        <= {NUM_CHANNELS{DOUT_INVERTED}};
                r_fco         <= FCO_INVERTED;
                r_dco         <= 1'b0;
                r_frame_start <= 1'b0;
            end

            if (!w_active || w_last) r_bit_cnt <= '0;
            else                     r_bit_cnt <= r_bit_cnt + 1'b1;

            // The TRAIN->RUN boundary already starts a live frame.
            if (!w_active) begin
                if (en) begin
                    r_shift     <= {NUM_CHANNELS{TRAIN_PATTERN}};
                    r_train_cnt <= '0;
                end
            end else if (w_boundary) begin
                if (w_train_next) begin
                    r_shift     <= {NUM_CHANNELS{TRAIN_PATTERN}};
                    r_train_cnt <= r_train_cnt + 1'b1;
                end else if (r_hold_valid) begin
                    r_shift      <= r_hold;
                    r_hold_valid <= 1'b0;
                end else begin
                    r_shift <= {NUM_CHANNELS{MIDSCALE}};
                    if (r_underflow != 16'hFFFF) r_underflow <= r_underflow + 1'b1;
                end
            end

            if (w_accept) begin
                r_hold       <= s_data;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign s_ready         = ~r_hold_valid;
    assign dout            = r_dout;
    assign fco             = r_fco;
    assign dco             = r_dco;
    assign frame_start     = r_frame_start;
    assign underflow_count = r_underflow;

endmodule

// File: tb/tb_ad9228_lvds_tx_emulator.sv
// Bench for ad9228_lvds_tx_emulator: a normal and an inverted-polarity instance run in
// lockstep against a frame-level stream model.
module tb_ad9228_lvds_tx_emulator;

    localparam logic [47:0] TRAIN_WORD = {4{12'hA5C}};
    localparam logic [47:0] MID_WORD   = {4{12'h800}};

    logic        clk = 1'b0;
    logic        rstn, en, s_valid;
    logic [47:0] s_data;

    logic [3:0]  dout_a, dout_b;
    logic        fco_a, dco_a, fs_a, rdy_a, fco_b, dco_b, fs_b, rdy_b;
    logic [15:0] uf_a, uf_b;
    logic [23:0] obs_a, obs_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ad9228_lvds_tx_emulator #(
        .NUM_CHANNELS(4), .DATA_WIDTH(12), .TRAIN_FRAMES(2), .TRAIN_PATTERN(12'hA5C),
        .DOUT_INVERTED(1'b0), .FCO_INVERTED(1'b0)
    ) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .s_valid(s_valid), .s_ready(rdy_a), .s_data(s_data),
        .dout(dout_a), .fco(fco_a), .dco(dco_a), .frame_start(fs_a), .underflow_count(uf_a)
    );

    ad9228_lvds_tx_emulator #(
        .NUM_CHANNELS(4), .DATA_WIDTH(12), .TRAIN_FRAMES(2), .TRAIN_PATTERN(12'hA5C),
        .DOUT_INVERTED(1'b1), .FCO_INVERTED(1'b1)
    ) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .s_valid(s_valid), .s_ready(rdy_b), .s_data(s_data),
        .dout(dout_b), .fco(fco_b), .dco(dco_b), .frame_start(fs_b), .underflow_count(uf_b)
    );

    assign obs_a = {dout_a, fco_a, dco_a, fs_a, rdy_a, uf_a};
    assign obs_b = {dout_b, fco_b, dco_b, fs_b, rdy_b, uf_b};

    // Stream model: which frame word is on the wire and at which bit position.
    bit          m_on = 1'b0;
    int          m_pos = 0;
    int          m_train_left = 0;
    bit          m_hold_valid = 1'b0;
    logic [47:0] m_hold = '0;
    logic [47:0] m_cur = '0;
    int          m_under = 0;
    bit          e_active = 1'b0;
    int          e_pos = 0;
    logic [47:0] e_word = '0;

    task automatic model_update(input bit r, input bit e, input bit v, input logic [47:0] d);
        bit accept;
        if (!r) begin
            m_on = 1'b0; m_hold_valid = 1'b0; m_under = 0; e_active = 1'b0;
        end else begin
            e_active = m_on; e_pos = m_pos; e_word = m_cur;
            accept = v && !m_hold_valid;
            if (!m_on) begin
                if (e) begin
                    m_on = 1'b1; m_pos = 0; m_cur = TRAIN_WORD; m_train_left = 1;
                end
            end else if (m_pos == 11) begin
                if (!e) m_on = 1'b0;
                else begin
                    m_pos = 0;
                    if (m_train_left > 0) begin
                        m_train_left--; m_cur = TRAIN_WORD;
                    end else if (m_hold_valid) begin
                        m_cur = m_hold; m_hold_valid = 1'b0;
                    end else begin
                        m_cur = MID_WORD;
                        if (m_under < 65535) m_under++;
                    end
                end
            end else m_pos++;
            if (accept) begin
                m_hold = d; m_hold_valid = 1'b1;
            end
        end
    endtask

    function automatic logic [23:0] exp_vec(input bit inv);
        logic [3:0]  d;
        logic        f, c, s;
        logic [11:0] w;
        d = '0; f = 1'b0; c = 1'b0; s = 1'b0;
        if (e_active) begin
            for (int i = 0; i < 4; i++) begin
                w    = e_word[i*12 +: 12];
                d[i] = w[11 - e_pos];
            end
            f = (e_pos < 6);
            c = (e_pos % 2 == 0);
            s = (e_pos == 0);
        end
        if (inv) begin
            d = ~d; f = ~f;
        end
        return {d, f, c, s, ~m_hold_valid, 16'(m_under)};
    endfunction

    task automatic step();
        bit r, e, v;
        logic [47:0] d;
        r = rstn; e = en; v = s_valid; d = s_data;
        @(posedge clk);
        model_update(r, e, v, d);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0;
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; s_valid = 1'b1; s_data = 48'h123456789ABC;
        step(); step();
        checks++;
        if ({dout_a, fco_a, dco_a, fs_a, rdy_a} !== 8'b0000_0001) begin
            errors++; $display("FAIL reset_idle_a: got %b expected 00000001", {dout_a, fco_a, dco_a, fs_a, rdy_a});
        end
        checks++;
        if (uf_a !== 16'd0) begin
            errors++; $display("FAIL reset_underflow: got %0d expected 0", uf_a);
        end
        checks++;
        if ({dout_b, fco_b, dco_b, fs_b} !== 7'b1111_100) begin
            errors++; $display("FAIL reset_idle_inv: got %b expected 1111100", {dout_b, fco_b, dco_b, fs_b});
        end
        rstn = 1'b1; en = 1'b0; s_valid = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_train_underflow();
        do_reset();
        for (int n = 1; n <= 64; n++) begin
            en = 1'b1;
            step();
            checks++;
            if (obs_a !== exp_vec(1'b0)) begin
                errors++; $display("FAIL train_a n=%0d: got %h expected %h", n, obs_a, exp_vec(1'b0));
            end
            checks++;
            if (obs_b !== exp_vec(1'b1)) begin
                errors++; $display("FAIL train_inv n=%0d: got %h expected %h", n, obs_b, exp_vec(1'b1));
            end
            if (n == 1) begin
                checks++;
                if ({dout_a, fs_a} !== 5'b0) begin
                    errors++; $display("FAIL train_latency: got %b expected 00000", {dout_a, fs_a});
                end
            end
            if (n == 2 || n == 26) begin
                checks++;
                if ({dout_a, fco_a, dco_a, fs_a} !== 7'b1111_111) begin
                    errors++; $display("FAIL frame_msb n=%0d: got %b expected 1111111", n, {dout_a, fco_a, dco_a, fs_a});
                end
            end
            if (n == 61) begin
                checks++;
                if (uf_a !== 16'd4) begin
                    errors++; $display("FAIL underflow_count: got %0d expected 4", uf_a);
                end
            end
        end
        $display("test_train_underflow done");
    endtask

    task automatic test_preload();
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            en = 1'b1;
            s_valid = (n == 5);
            s_data = {12'hABC, 12'h789, 12'h456, 12'h123};
            step();
            checks++;
            if (obs_a !== exp_vec(1'b0)) begin
                errors++; $display("FAIL preload_a n=%0d: got %h expected %h", n, obs_a, exp_vec(1'b0));
            end
            if (n == 24 || n == 25) begin
                checks++;
                if (rdy_a !== (n == 25)) begin
                    errors++; $display("FAIL preload_ready n=%0d: got %b expected %b", n, rdy_a, n == 25);
                end
            end
            if (n == 26) begin
                checks++;
                if ({dout_a, fs_a} !== 5'b1000_1) begin
                    errors++; $display("FAIL preload_first_bit: got %b expected 10001", {dout_a, fs_a});
                end
            end
            if (n == 36) begin
                checks++;
                if (uf_a !== 16'd0) begin
                    errors++; $display("FAIL preload_underflow: got %0d expected 0", uf_a);
                end
            end
        end
        s_valid = 1'b0;
        $display("test_preload done");
    endtask

    task automatic test_back_to_back();
        logic [11:0] w;
        int accepts;
        bit acc;
        do_reset();
        w = 12'($urandom());
        accepts = 0;
        for (int n = 1; n <= 121; n++) begin
            en = 1'b1; s_valid = 1'b1;
            s_data = {w + 12'd3, w + 12'd2, w + 12'd1, w};
            acc = rdy_a;
            step();
            if (acc) begin
                $display("accepted word %h at n=%0d", s_data, n);
                accepts++;
                w = w + 12'd4;
            end
            checks++;
            if (obs_a !== exp_vec(1'b0)) begin
                errors++; $display("FAIL b2b_a n=%0d: got %h expected %h", n, obs_a, exp_vec(1'b0));
            end
        end
        checks++;
        if (accepts != 9) begin
            errors++; $display("FAIL b2b_accepts: got %0d expected 9", accepts);
        end
        checks++;
        if (uf_a !== 16'd0) begin
            errors++; $display("FAIL b2b_underflow: got %0d expected 0", uf_a);
        end
        s_valid = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_stop();
        do_reset();
        for (int n = 1; n <= 52; n++) begin
            en = (n <= 40);
            step();
            checks++;
            if (obs_a !== exp_vec(1'b0)) begin
                errors++; $display("FAIL stop_a n=%0d: got %h expected %h", n, obs_a, exp_vec(1'b0));
            end
            checks++;
            if (obs_b !== exp_vec(1'b1)) begin
                errors++; $display("FAIL stop_inv n=%0d: got %h expected %h", n, obs_b, exp_vec(1'b1));
            end
            if (n == 48) begin
                checks++;
                if (dco_a !== 1'b1) begin
                    errors++; $display("FAIL stop_frame_continues: dco got %b expected 1", dco_a);
                end
            end
            if (n == 50) begin
                checks++;
                if ({dout_a, fco_a, dco_a, fs_a} !== 7'b0) begin
                    errors++; $display("FAIL stop_idle: got %b expected 0000000", {dout_a, fco_a, dco_a, fs_a});
                end
            end
        end
        $display("test_stop done");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int n = 1; n <= 46; n++) begin
            rstn = (n != 42);
            en = 1'b1;
            s_valid = (n == 38);
            s_data = 48'({$urandom(), $urandom()});
            step();
            checks++;
            if (obs_a !== exp_vec(1'b0)) begin
                errors++; $display("FAIL midrst_a n=%0d: got %h expected %h", n, obs_a, exp_vec(1'b0));
            end
            if (n == 41) begin
                checks++;
                if ({rdy_a, uf_a} !== {1'b0, 16'd2}) begin
                    errors++; $display("FAIL midrst_before: got %b/%0d expected 0/2", rdy_a, uf_a);
                end
            end
            if (n == 42) begin
                checks++;
                if ({dout_a, fco_a, dco_a, fs_a, rdy_a, uf_a} !== {8'b0000_0001, 16'd0}) begin
                    errors++; $display("FAIL midrst_after: got %h expected 010000", {dout_a, fco_a, dco_a, fs_a, rdy_a, uf_a});
                end
            end
            if (n == 44) begin
                checks++;
                if ({dout_a, fs_a} !== 5'b1111_1) begin
                    errors++; $display("FAIL midrst_retrain: got %b expected 11111", {dout_a, fs_a});
                end
            end
        end
        s_valid = 1'b0;
        $display("test_reset_midframe done");
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 1; n <= 600; n++) begin
            rstn    = ($urandom_range(0, 99) >= 2);
            en      = ($urandom_range(0, 19) != 0);
            s_valid = $urandom_range(0, 1) == 1;
            s_data  = 48'({$urandom(), $urandom()});
            step();
            checks++;
            if (obs_a !== exp_vec(1'b0)) begin
                errors++; $display("FAIL random_a n=%0d: got %h expected %h", n, obs_a, exp_vec(1'b0));
            end
            checks++;
            if (obs_b !== exp_vec(1'b1)) begin
                errors++; $display("FAIL random_inv n=%0d: got %h expected %h", n, obs_b, exp_vec(1'b1));
            end
        end
        $display("test_random done");
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0;
        test_reset();
        test_train_underflow();
        test_preload();
        test_back_to_back();
        test_stop();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
